// File: rtl/bp_sac_io_req_tracker.sv
// Uncached I/O command/response tracker for the SAC accelerator port.
// Buffers commands, limits in-flight count, holds responses, flags errors.
module bp_sac_io_req_tracker #(
  parameter int msg_width_p       = 100,
  parameter int max_outstanding_p = 2,
  parameter int timeout_cycles_p  = 1024
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [msg_width_p-1:0] acc_cmd_i,
  input  logic                   acc_cmd_v_i,
  output logic                   acc_cmd_ready_o,
  output logic [msg_width_p-1:0] acc_resp_o,
  output logic                   acc_resp_v_o,
  input  logic                   acc_resp_yumi_i,
  output logic [msg_width_p-1:0] net_cmd_o,
  output logic                   net_cmd_v_o,
  input  logic                   net_cmd_yumi_i,
  input  logic [msg_width_p-1:0] net_resp_i,
  input  logic                   net_resp_v_i,
  output logic                   net_resp_ready_o,
  input  logic                   clear_i,
  output logic [2:0]             outstanding_o,
  output logic                   idle_o,
  output logic                   timeout_err_o,
  output logic                   stray_err_o
);

  localparam int tw_lp = $clog2(timeout_cycles_p + 1);
  localparam logic [2:0] max_os_lp = 3'(max_outstanding_p);
  localparam logic [tw_lp-1:0] to_max_lp = tw_lp'(timeout_cycles_p);

  logic [msg_width_p-1:0] mem0_q, mem0_d;
  logic [msg_width_p-1:0] mem1_q, mem1_d;
  logic                   wr_q, wr_d;
  logic                   rd_q, rd_d;
  logic [1:0]             cnt_q, cnt_d;
  logic [2:0]             os_q, os_d;
  logic [msg_width_p-1:0] resp_data_q, resp_data_d;
  logic                   resp_full_q, resp_full_d;
  logic [tw_lp-1:0]       tcnt_q, tcnt_d;
  logic                   to_err_q, to_err_d;
  logic                   stray_q, stray_d;

  logic fifo_full, fifo_empty, credit;
  logic enq, deq;
  logic resp_acc, resp_cnt, resp_stray;

  // Handshakes and status outputs, all from registered state
  always_comb begin
    fifo_full        = (cnt_q == 2'd2);
    fifo_empty       = (cnt_q == 2'd0);
    credit           = (os_q < max_os_lp);
    acc_cmd_ready_o  = ~fifo_full;
    net_cmd_v_o      = ~fifo_empty & credit;
    net_cmd_o        = rd_q ? mem1_q : mem0_q;
    net_resp_ready_o = ~resp_full_q;
    acc_resp_v_o     = resp_full_q;
    acc_resp_o       = resp_data_q;
    enq              = acc_cmd_v_i & ~fifo_full;
    deq              = net_cmd_yumi_i & ~fifo_empty & credit;
    resp_acc         = net_resp_v_i & ~resp_full_q;
    resp_cnt         = resp_acc & (os_q != 3'd0);
    resp_stray       = resp_acc & (os_q == 3'd0);
    outstanding_o    = os_q;
    idle_o           = fifo_empty & (os_q == 3'd0)
                     & ~resp_full_q;
    timeout_err_o    = to_err_q;
    stray_err_o      = stray_q;
  end

  // Next-state for FIFO, credit count, resp buffer, timeout, flags
  always_comb begin
    mem0_d      = mem0_q;
    mem1_d      = mem1_q;
    wr_d        = wr_q;
    rd_d        = rd_q;
    cnt_d       = cnt_q;
    os_d        = os_q;
    resp_data_d = resp_data_q;
    resp_full_d = resp_full_q;
    tcnt_d      = tcnt_q;

    if (enq) begin
      if (wr_q) mem1_d = acc_cmd_i;
      else      mem0_d = acc_cmd_i;
      wr_d = ~wr_q;
    end
    if (deq) rd_d = ~rd_q;

    case ({enq, deq})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase

    case ({deq, resp_cnt})
      2'b10:   os_d = os_q + 3'd1;
      2'b01:   os_d = os_q - 3'd1;
      default: os_d = os_q;
    endcase

    if (acc_resp_yumi_i & resp_full_q) resp_full_d = 1'b0;
    if (resp_cnt) begin
      resp_full_d = 1'b1;
      resp_data_d = net_resp_i;
    end

    if ((os_q == 3'd0) | resp_acc)
      tcnt_d = '0;
    else if (tcnt_q != to_max_lp)
      tcnt_d = tcnt_q + tw_lp'(1);

    // Set wins over clear on the sticky flags
    to_err_d = (to_err_q & ~clear_i) | (tcnt_q == to_max_lp);
    stray_d  = (stray_q & ~clear_i) | resp_stray;
  end

  // State registers, asynchronously reset
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      mem0_q      <= '0;
      mem1_q      <= '0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      cnt_q       <= 2'd0;
      os_q        <= 3'd0;
      resp_data_q <= '0;
      resp_full_q <= 1'b0;
      tcnt_q      <= '0;
      to_err_q    <= 1'b0;
      stray_q     <= 1'b0;
    end else begin
      mem0_q      <= mem0_d;
      mem1_q      <= mem1_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
      os_q        <= os_d;
      resp_data_q <= resp_data_d;
      resp_full_q <= resp_full_d;
      tcnt_q      <= tcnt_d;
      to_err_q    <= to_err_d;
      stray_q     <= stray_d;
    end
  end

endmodule

// File: tb/tb_bp_sac_io_req_tracker.sv
// Bench for bp_sac_io_req_tracker: scoreboarded cmd/resp paths,
// credit limit, backpressure, stray, timeout and async reset.
module tb_bp_sac_io_req_tracker;

  localparam int W = 100;

  logic         clk;
  logic         reset_i;
  logic [W-1:0] acc_cmd_i;
  logic         acc_cmd_v_i;
  logic         acc_cmd_ready_o;
  logic [W-1:0] acc_resp_o;
  logic         acc_resp_v_o;
  logic         acc_resp_yumi_i;
  logic [W-1:0] net_cmd_o;
  logic         net_cmd_v_o;
  logic         net_cmd_yumi_i;
  logic [W-1:0] net_resp_i;
  logic         net_resp_v_i;
  logic         net_resp_ready_o;
  logic         clear_i;
  logic [2:0]   outstanding_o;
  logic         idle_o;
  logic         timeout_err_o;
  logic         stray_err_o;

  logic net_yumi_en;
  logic acc_yumi_en;

  int total = 0;
  int bad = 0;

  logic [W-1:0] cmd_q[$];
  logic [W-1:0] resp_q[$];
  logic [W-1:0] exp_c;
  logic [W-1:0] exp_r;

  assign net_cmd_yumi_i  = net_yumi_en & net_cmd_v_o;
  assign acc_resp_yumi_i = acc_yumi_en & acc_resp_v_o;

  bp_sac_io_req_tracker #(
    .msg_width_p(W),
    .max_outstanding_p(2),
    .timeout_cycles_p(16)
  ) dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .acc_cmd_i(acc_cmd_i),
    .acc_cmd_v_i(acc_cmd_v_i),
    .acc_cmd_ready_o(acc_cmd_ready_o),
    .acc_resp_o(acc_resp_o),
    .acc_resp_v_o(acc_resp_v_o),
    .acc_resp_yumi_i(acc_resp_yumi_i),
    .net_cmd_o(net_cmd_o),
    .net_cmd_v_o(net_cmd_v_o),
    .net_cmd_yumi_i(net_cmd_yumi_i),
    .net_resp_i(net_resp_i),
    .net_resp_v_i(net_resp_v_i),
    .net_resp_ready_o(net_resp_ready_o),
    .clear_i(clear_i),
    .outstanding_o(outstanding_o),
    .idle_o(idle_o),
    .timeout_err_o(timeout_err_o),
    .stray_err_o(stray_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] rnd_msg();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[W-1:0];
  endfunction

  // Pop and compare at every completed handshake
  always @(negedge clk) begin
    if (!reset_i) begin
      if (net_cmd_v_o && net_cmd_yumi_i) begin
        total++;
        if (cmd_q.size() == 0) begin
          bad++;
          $display("FAIL net_cmd_extra: got %h want none", net_cmd_o);
        end else begin
          exp_c = cmd_q.pop_front();
          if (net_cmd_o !== exp_c) begin
            bad++;
            $display("FAIL net_cmd_data: got %h want %h",
                     net_cmd_o, exp_c);
          end
        end
      end
      if (acc_resp_v_o && acc_resp_yumi_i) begin
        total++;
        if (resp_q.size() == 0) begin
          bad++;
          $display("FAIL acc_resp_extra: got %h want none", acc_resp_o);
        end else begin
          exp_r = resp_q.pop_front();
          if (acc_resp_o !== exp_r) begin
            bad++;
            $display("FAIL acc_resp_data: got %h want %h",
                     acc_resp_o, exp_r);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [W-1:0] d);
    int n;
    n = 0;
    acc_cmd_v_i = 1'b1;
    acc_cmd_i   = d;
    @(negedge clk);
    while (!acc_cmd_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!acc_cmd_ready_o) begin
      bad++;
      $display("FAIL cmd_ready_wait: got 0 want 1 within 50 cycles");
    end else begin
      cmd_q.push_back(d);
    end
    tick();
    acc_cmd_v_i = 1'b0;
  endtask

  task automatic send_resp(input logic [W-1:0] d, input logic fwd);
    int n;
    n = 0;
    net_resp_v_i = 1'b1;
    net_resp_i   = d;
    @(negedge clk);
    while (!net_resp_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!net_resp_ready_o) begin
      bad++;
      $display("FAIL resp_ready_wait: got 0 want 1 within 50 cycles");
    end else if (fwd) begin
      resp_q.push_back(d);
    end
    tick();
    net_resp_v_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i      = 1'b1;
    acc_cmd_i    = '0;
    acc_cmd_v_i  = 1'b0;
    net_resp_i   = '0;
    net_resp_v_i = 1'b0;
    clear_i      = 1'b0;
    net_yumi_en  = 1'b0;
    acc_yumi_en  = 1'b0;
    #1;
    total++;
    if ({acc_cmd_ready_o, acc_resp_v_o, net_cmd_v_o,
         net_resp_ready_o, outstanding_o, idle_o,
         timeout_err_o, stray_err_o} !== 10'b1001_000_1_00) begin
      bad++;
      $display("FAIL reset_outs: got %b %b %b %b %0d %b %b %b want 1 0 0 1 0 1 0 0",
               acc_cmd_ready_o, acc_resp_v_o, net_cmd_v_o,
               net_resp_ready_o, outstanding_o, idle_o,
               timeout_err_o, stray_err_o);
    end
    tick();
    tick();
    reset_i = 1'b0;
    @(negedge clk);
    total++;
    if (idle_o !== 1'b1 || outstanding_o !== 3'd0) begin
      bad++;
      $display("FAIL reset_release: got idle=%b os=%0d want idle=1 os=0",
               idle_o, outstanding_o);
    end
    tick();
  endtask

  task automatic test_single_read();
    send_cmd(rnd_msg());
    @(negedge clk);
    total++;
    if (net_cmd_v_o !== 1'b1 || outstanding_o !== 3'd0
        || idle_o !== 1'b0) begin
      bad++;
      $display("FAIL t1_queued: got v=%b os=%0d idle=%b want v=1 os=0 idle=0",
               net_cmd_v_o, outstanding_o, idle_o);
    end
    tick();
    net_yumi_en = 1'b1;
    tick();
    net_yumi_en = 1'b0;
    @(negedge clk);
    total++;
    if (outstanding_o !== 3'd1 || net_cmd_v_o !== 1'b0) begin
      bad++;
      $display("FAIL t1_issued: got os=%0d v=%b want os=1 v=0",
               outstanding_o, net_cmd_v_o);
    end
    repeat (4) tick();
    send_resp(rnd_msg(), 1'b1);
    @(negedge clk);
    total++;
    if (acc_resp_v_o !== 1'b1 || outstanding_o !== 3'd0) begin
      bad++;
      $display("FAIL t1_resp_held: got v=%b os=%0d want v=1 os=0",
               acc_resp_v_o, outstanding_o);
    end
    tick();
    acc_yumi_en = 1'b1;
    tick();
    acc_yumi_en = 1'b0;
    @(negedge clk);
    total++;
    if (acc_resp_v_o !== 1'b0 || idle_o !== 1'b1) begin
      bad++;
      $display("FAIL t1_done: got v=%b idle=%b want v=0 idle=1",
               acc_resp_v_o, idle_o);
    end
    tick();
  endtask

  task automatic test_credit_limit();
    net_yumi_en = 1'b1;
    acc_yumi_en = 1'b1;
    send_cmd(rnd_msg());
    send_cmd(rnd_msg());
    send_cmd(rnd_msg());
    tick();
    @(negedge clk);
    total++;
    if (net_cmd_v_o !== 1'b0 || outstanding_o !== 3'd2
        || cmd_q.size() != 1) begin
      bad++;
      $display("FAIL t2_limit: got v=%b os=%0d q=%0d want v=0 os=2 q=1",
               net_cmd_v_o, outstanding_o, cmd_q.size());
    end
    tick();
    send_resp(rnd_msg(), 1'b1);
    @(negedge clk);
    total++;
    if (net_cmd_v_o !== 1'b1 || outstanding_o !== 3'd1) begin
      bad++;
      $display("FAIL t2_reissue: got v=%b os=%0d want v=1 os=1",
               net_cmd_v_o, outstanding_o);
    end
    tick();
    @(negedge clk);
    total++;
    if (outstanding_o !== 3'd2 || cmd_q.size() != 0) begin
      bad++;
      $display("FAIL t2_third: got os=%0d q=%0d want os=2 q=0",
               outstanding_o, cmd_q.size());
    end
    tick();
    send_resp(rnd_msg(), 1'b1);
    send_resp(rnd_msg(), 1'b1);
    repeat (3) tick();
    @(negedge clk);
    total++;
    if (idle_o !== 1'b1 || resp_q.size() != 0) begin
      bad++;
      $display("FAIL t2_drain: got idle=%b q=%0d want idle=1 q=0",
               idle_o, resp_q.size());
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] r2;
    net_yumi_en = 1'b1;
    acc_yumi_en = 1'b0;
    send_cmd(rnd_msg());
    send_cmd(rnd_msg());
    tick();
    @(negedge clk);
    total++;
    if (outstanding_o !== 3'd2) begin
      bad++;
      $display("FAIL t3_os: got %0d want 2", outstanding_o);
    end
    tick();
    send_resp(rnd_msg(), 1'b1);
    r2 = rnd_msg();
    net_resp_v_i = 1'b1;
    net_resp_i   = r2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (net_resp_ready_o !== 1'b0 || acc_resp_v_o !== 1'b1) begin
        bad++;
        $display("FAIL t3_backpressure: got rdy=%b v=%b want rdy=0 v=1",
                 net_resp_ready_o, acc_resp_v_o);
      end
      tick();
    end
    acc_yumi_en = 1'b1;
    send_resp(r2, 1'b1);
    repeat (3) tick();
    @(negedge clk);
    total++;
    if (outstanding_o !== 3'd0 || idle_o !== 1'b1
        || resp_q.size() != 0) begin
      bad++;
      $display("FAIL t3_drain: got os=%0d idle=%b q=%0d want 0 1 0",
               outstanding_o, idle_o, resp_q.size());
    end
    tick();
  endtask

  task automatic test_stray();
    send_resp(rnd_msg(), 1'b0);
    @(negedge clk);
    total++;
    if (stray_err_o !== 1'b1 || acc_resp_v_o !== 1'b0
        || outstanding_o !== 3'd0) begin
      bad++;
      $display("FAIL t4_stray: got err=%b v=%b os=%0d want 1 0 0",
               stray_err_o, acc_resp_v_o, outstanding_o);
    end
    tick();
    clear_i = 1'b1;
    send_resp(rnd_msg(), 1'b0);
    clear_i = 1'b0;
    @(negedge clk);
    total++;
    if (stray_err_o !== 1'b1) begin
      bad++;
      $display("FAIL t4_set_wins: got %b want 1", stray_err_o);
    end
    tick();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    @(negedge clk);
    total++;
    if (stray_err_o !== 1'b0) begin
      bad++;
      $display("FAIL t4_clear: got %b want 0", stray_err_o);
    end
    tick();
  endtask

  task automatic test_timeout();
    net_yumi_en = 1'b1;
    acc_yumi_en = 1'b1;
    send_cmd(rnd_msg());
    @(posedge clk);
    repeat (16) @(posedge clk);
    @(negedge clk);
    total++;
    if (timeout_err_o !== 1'b0 || outstanding_o !== 3'd1) begin
      bad++;
      $display("FAIL t5_early: got err=%b os=%0d want err=0 os=1",
               timeout_err_o, outstanding_o);
    end
    @(negedge clk);
    total++;
    if (timeout_err_o !== 1'b1) begin
      bad++;
      $display("FAIL t5_rise: got %b want 1", timeout_err_o);
    end
    tick();
    send_resp(rnd_msg(), 1'b1);
    repeat (2) tick();
    @(negedge clk);
    total++;
    if (outstanding_o !== 3'd0 || timeout_err_o !== 1'b1
        || resp_q.size() != 0) begin
      bad++;
      $display("FAIL t5_late: got os=%0d err=%b q=%0d want 0 1 0",
               outstanding_o, timeout_err_o, resp_q.size());
    end
    tick();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    @(negedge clk);
    total++;
    if (timeout_err_o !== 1'b0) begin
      bad++;
      $display("FAIL t5_clear: got %b want 0", timeout_err_o);
    end
    tick();
  endtask

  task automatic test_async_reset();
    net_yumi_en = 1'b1;
    acc_yumi_en = 1'b0;
    for (int i = 0; i < 4; i++) send_cmd(rnd_msg());
    @(negedge clk);
    total++;
    if (acc_cmd_ready_o !== 1'b0 || outstanding_o !== 3'd2) begin
      bad++;
      $display("FAIL t6_loaded: got rdy=%b os=%0d want rdy=0 os=2",
               acc_cmd_ready_o, outstanding_o);
    end
    #2;
    reset_i = 1'b1;
    #1;
    total++;
    if ({acc_cmd_ready_o, acc_resp_v_o, net_cmd_v_o,
         net_resp_ready_o, outstanding_o, idle_o,
         timeout_err_o, stray_err_o} !== 10'b1001_000_1_00) begin
      bad++;
      $display("FAIL t6_async: got %b %b %b %b %0d %b %b %b want 1 0 0 1 0 1 0 0",
               acc_cmd_ready_o, acc_resp_v_o, net_cmd_v_o,
               net_resp_ready_o, outstanding_o, idle_o,
               timeout_err_o, stray_err_o);
    end
    cmd_q.delete();
    resp_q.delete();
    tick();
    reset_i = 1'b0;
    send_resp(rnd_msg(), 1'b0);
    @(negedge clk);
    total++;
    if (stray_err_o !== 1'b1 || acc_resp_v_o !== 1'b0) begin
      bad++;
      $display("FAIL t6_late_stray: got err=%b v=%b want err=1 v=0",
               stray_err_o, acc_resp_v_o);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_credit_limit();
    test_back_to_back();
    test_stray();
    test_timeout();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
